// File: rtl/sdram_write_buffer_if.sv
// SDRAM-side write request bus of the write buffer.
// The master drives the request; the slave (controller) returns the ack.
interface sdram_write_buffer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
);
    logic              o_sdramWrReq;
    logic [ADDR_W-1:0] o_sdramAddr;
    logic [DATA_W-1:0] o_sdramData;
    logic              i_sdramWrAck;

    modport master (
        output o_sdramWrReq,
        output o_sdramAddr,
        output o_sdramData,
        input  i_sdramWrAck
    );

    modport slave (
        input  o_sdramWrReq,
        input  o_sdramAddr,
        input  o_sdramData,
        output i_sdramWrAck
    );
endinterface

// File: rtl/sdram_write_buffer.sv
// FIFO of {addr,data} write words feeding an SDRAM controller request port.
// Optional sticky overflow flag enabled by SDRAM_WRBUF_OVERFLOW_EN.
module sdram_write_buffer #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 19
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_enableWrite,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_busy,
    input  logic              i_clrOverflow,
    output logic              o_overflow,
    sdram_write_buffer_if.master sd
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of 2 and at least 4");
    end

    typedef enum logic {
        S_IDLE,
        S_REQ
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_mem_addr [DEPTH];
    logic [DATA_W-1:0] r_mem_data [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic [CW-1:0]     w_count_nxt;
    logic              r_full;
    logic              r_empty;
    logic              r_avail;
    logic              r_req;
    logic [ADDR_W-1:0] r_out_addr;
    logic [DATA_W-1:0] r_out_data;
    logic              w_push;
    logic              w_pop;
    logic              w_ack;

    assign w_ack  = sd.i_sdramWrAck;
    assign w_push = i_enableWrite & ~r_full;

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            // r_avail delays the idle launch one cycle behind the flags
            S_IDLE: begin
                if (r_avail && !r_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (w_ack) begin
                    if (!r_empty) begin
                        w_pop = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CW'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
            r_avail <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CW'(DEPTH));
            r_empty <= (w_count_nxt == '0);
            r_avail <= ~r_empty;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_addr[r_wptr] <= i_addr;
            r_mem_data[r_wptr] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_req      <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
        end else if (w_pop) begin
            r_req      <= 1'b1;
            r_out_addr <= r_mem_addr[r_rptr];
            r_out_data <= r_mem_data[r_rptr];
        end else if (r_state == S_REQ && w_ack) begin
            r_req <= 1'b0;
        end
    end

`ifdef SDRAM_WRBUF_OVERFLOW_EN
    logic r_overflow;

    // a drop in the same cycle as a clear keeps the flag set
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_overflow <= 1'b0;
        end else if (i_enableWrite && r_full) begin
            r_overflow <= 1'b1;
        end else if (i_clrOverflow) begin
            r_overflow <= 1'b0;
        end
    end

    assign o_overflow = r_overflow;
`else
    logic w_unused_clr;

    assign w_unused_clr = i_clrOverflow;
    assign o_overflow   = 1'b0;
`endif

    assign o_full          = r_full;
    assign o_empty         = r_empty;
    assign o_busy          = r_req | ~r_empty;
    assign sd.o_sdramWrReq = r_req;
    assign sd.o_sdramAddr  = r_out_addr;
    assign sd.o_sdramData  = r_out_data;
endmodule

// File: tb/tb_sdram_write_buffer.sv
// Self-checking bench for sdram_write_buffer: vector table plus
// scoreboard of expected SDRAM writes.
module tb_sdram_write_buffer;
    localparam int DEPTH  = 16;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 19;
`ifdef SDRAM_WRBUF_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic              clr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic              full;
    logic              empty;
    logic              busy;
    logic              ovf;

    sdram_write_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) sif ();

    sdram_write_buffer #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_data       (data),
        .i_addr       (addr),
        .i_enableWrite(en),
        .o_full       (full),
        .o_empty      (empty),
        .o_busy       (busy),
        .i_clrOverflow(clr),
        .o_overflow   (ovf),
        .sd           (sif.master)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
    } word_t;

    typedef struct {
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                ack_dly;
        int                lat;
    } vec_t;

    word_t sb[$];
    vec_t  vt[3];
    int    n_chk  = 0;
    int    n_fail = 0;
    int    n_xfer = 0;

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(string tag);
        check({tag, "_empty"}, empty, 1);
        check({tag, "_full"}, full, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_req"}, sif.o_sdramWrReq, 0);
        check({tag, "_addr"}, sif.o_sdramAddr, 0);
        check({tag, "_data"}, sif.o_sdramData, 0);
        check({tag, "_ovf"}, ovf, 0);
    endtask

    // a transfer completes at the next rising edge when req and ack are both high
    always @(negedge clk) begin
        if (rst_n && sif.o_sdramWrReq && sif.i_sdramWrAck) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_underflow: got addr %0h with no word expected",
                         sif.o_sdramAddr);
            end else begin
                word_t e;
                e = sb.pop_front();
                check("xfer_addr", sif.o_sdramAddr, e.a);
                check("xfer_data", sif.o_sdramData, e.d);
                n_xfer++;
            end
        end
    end

    initial begin
        logic [7:0] pat;
        int         cyc;
        int         wr;
        int         x0;

        vt[0] = '{19'h00010, 16'hBEEF, 3, 2};
        vt[1] = '{19'h7FFFF, 16'h0001, 0, 2};
        vt[2] = '{19'h00000, 16'hFFFF, 1, 2};

        rst_n = 1'b0;
        en    = 1'b0;
        clr   = 1'b0;
        addr  = '0;
        data  = '0;
        sif.i_sdramWrAck = 1'b0;
        step();
        step();
        check_reset("rst");
        rst_n = 1'b1;
        step();

        // single writes: latency, hold until ack, release
        for (int i = 0; i < 3; i++) begin
            en   = 1'b1;
            addr = vt[i].a;
            data = vt[i].d;
            sb.push_back(word_t'{vt[i].a, vt[i].d});
            step();
            en = 1'b0;
            check("t1_empty", empty, 0);
            for (int c = 1; c <= vt[i].lat; c++) begin
                step();
                check("t1_req_lat", sif.o_sdramWrReq, (c == vt[i].lat));
            end
            check("t1_addr", sif.o_sdramAddr, vt[i].a);
            check("t1_data", sif.o_sdramData, vt[i].d);
            for (int d = 0; d < vt[i].ack_dly; d++) begin
                step();
                check("t1_hold_req", sif.o_sdramWrReq, 1);
                check("t1_hold_addr", sif.o_sdramAddr, vt[i].a);
                check("t1_hold_data", sif.o_sdramData, vt[i].d);
            end
            sif.i_sdramWrAck = 1'b1;
            step();
            sif.i_sdramWrAck = 1'b0;
            check("t1_req_drop", sif.o_sdramWrReq, 0);
            check("t1_busy", busy, 0);
            check("t1_empty_end", empty, 1);
        end

        // ack in idle is ignored
        sif.i_sdramWrAck = 1'b1;
        step();
        sif.i_sdramWrAck = 1'b0;
        step();
        check("idle_ack_req", sif.o_sdramWrReq, 0);
        check("idle_ack_busy", busy, 0);

        // four writes, ack held high: back-to-back requests
        sif.i_sdramWrAck = 1'b1;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            en   = 1'b1;
            addr = ADDR_W'(i + 1);
            data = DATA_W'(16'hA001 + i);
            sb.push_back(word_t'{addr, data});
            step();
            pat[i] = sif.o_sdramWrReq;
        end
        en = 1'b0;
        for (int i = 4; i < 8; i++) begin
            step();
            pat[i] = sif.o_sdramWrReq;
        end
        sif.i_sdramWrAck = 1'b0;
        check("b2b_pattern", pat, 8'b0011_1100);
        check("b2b_sb_empty", sb.size(), 0);

        // overflow: 18 writes, ack held low
        for (int i = 0; i < 18; i++) begin
            en   = 1'b1;
            addr = ADDR_W'(19'h00100 + i);
            data = DATA_W'(16'hC000 + i);
            if (i < 17) sb.push_back(word_t'{addr, data});
            step();
            if (i == 15) check("ovf_not_full", full, 0);
            if (i == 16) check("ovf_full", full, 1);
        end
        en = 1'b0;
        check("ovf_full_hold", full, 1);
        check("ovf_flag", ovf, OVF_EN);
        check("ovf_req_head", sif.o_sdramAddr, 19'h00100);
        en   = 1'b1;
        clr  = 1'b1;
        addr = 19'h001EE;
        step();
        en  = 1'b0;
        clr = 1'b0;
        check("ovf_set_wins", ovf, OVF_EN);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("ovf_clear", ovf, 0);
        check("ovf_still_full", full, 1);

        // full FIFO: push refused, pop taken in the same cycle
        en   = 1'b1;
        addr = 19'h001FF;
        data = 16'hDEAD;
        sif.i_sdramWrAck = 1'b1;
        step();
        en = 1'b0;
        sif.i_sdramWrAck = 1'b0;
        check("pp_full_clear", full, 0);
        check("pp_req", sif.o_sdramWrReq, 1);
        sif.i_sdramWrAck = 1'b1;
        cyc = 0;
        while (busy && cyc < 200) begin
            step();
            cyc++;
        end
        sif.i_sdramWrAck = 1'b0;
        check("drain_timeout", (cyc < 200), 1);
        check("drain_sb_empty", sb.size(), 0);

        // reset in the middle of a request with words queued
        for (int i = 0; i < 6; i++) begin
            en   = 1'b1;
            addr = ADDR_W'(19'h00200 + i);
            data = DATA_W'(16'h5000 + i);
            sb.push_back(word_t'{addr, data});
            step();
        end
        en = 1'b0;
        step();
        check("mid_req", sif.o_sdramWrReq, 1);
        check("mid_empty", empty, 0);
        rst_n = 1'b0;
        sif.i_sdramWrAck = 1'b1;
        step();
        check_reset("mid_rst");
        rst_n = 1'b1;
        sif.i_sdramWrAck = 1'b0;
        sb.delete();
        step();
        sif.i_sdramWrAck = 1'b1;
        step();
        sif.i_sdramWrAck = 1'b0;
        step();
        step();
        check("post_rst_req", sif.o_sdramWrReq, 0);
        check("post_rst_busy", busy, 0);
        check("post_rst_empty", empty, 1);

        // 40 words with random write and ack gaps; pointers wrap
        wr  = 0;
        cyc = 0;
        x0  = n_xfer;
        while ((wr < 40 || busy) && cyc < 3000) begin
            en = 1'b0;
            if (wr < 40 && !full && $urandom_range(0, 1) == 1) begin
                en   = 1'b1;
                addr = ADDR_W'(19'h40000 + wr * 19'h111);
                data = DATA_W'($urandom);
                sb.push_back(word_t'{addr, data});
                wr++;
            end
            sif.i_sdramWrAck = sif.o_sdramWrReq &&
                               ($urandom_range(0, 3) != 0);
            step();
            cyc++;
        end
        en = 1'b0;
        sif.i_sdramWrAck = 1'b0;
        check("rand_timeout", (cyc < 3000), 1);
        check("rand_count", n_xfer - x0, 40);
        check("rand_sb_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_write_buffer.md
SDRAM_WRITE_BUFFER -- requirements
Module: sdram_write_buffer

Interface
REQ-001 Parameter DEPTH, default 16, FIFO entries; SHALL be a power of 2, minimum 4.
REQ-002 Parameter DATA_W, default 16, SDRAM word width.
REQ-003 Parameter ADDR_W, default 19, SDRAM word address width.
REQ-004 i_clk  input  1  sole clock; all logic on rising edge.
REQ-005 i_rst_n  input  1  synchronous active-low reset.
REQ-006 i_data  input  DATA_W  write word from the upstream write-stream selector.
REQ-007 i_addr  input  ADDR_W  write address from the upstream selector.
REQ-008 i_enableWrite  input  1  qualifies i_data/i_addr for one cycle.
REQ-009 o_full  output  1  FIFO holds DEPTH entries; upstream SHALL NOT assert i_enableWrite.
REQ-010 o_empty  output  1  FIFO holds zero entries.
REQ-011 o_busy  output  1  o_sdramWrReq high or FIFO non-empty.
REQ-012 o_sdramWrReq  output  1  write request to the SDRAM controller.
REQ-013 o_sdramAddr  output  ADDR_W  address presented with o_sdramWrReq.
REQ-014 o_sdramData  output  DATA_W  data presented with o_sdramWrReq.
REQ-015 i_sdramWrAck  input  1  single-cycle pulse; controller accepted the current request.
REQ-016 i_clrOverflow  input  1  clears o_overflow (see Configuration).
REQ-017 o_overflow  output  1  sticky: a write was attempted while full.

Function
REQ-018 FIFO SHALL store {addr,data} pairs; push when i_enableWrite=1 and o_full=0 at the edge.
REQ-019 i_enableWrite while o_full=1 SHALL be dropped; FIFO contents and pointers unchanged.
REQ-020 o_full/o_empty SHALL be registered, derived from an occupancy counter of width log2(DEPTH)+1.
REQ-021 Read/write pointers SHALL wrap from DEPTH-1 to 0.
REQ-022 Simultaneous push and pop SHALL leave occupancy unchanged; push while full is refused even if a pop occurs that cycle.
REQ-023 Output FSM states: IDLE, REQ.
REQ-024 IDLE: if FIFO non-empty, pop head into o_sdramAddr/o_sdramData, set o_sdramWrReq=1, go REQ; else stay IDLE.
REQ-025 REQ: o_sdramWrReq, o_sdramAddr, o_sdramData SHALL hold stable until i_sdramWrAck=1 is sampled.
REQ-026 REQ with ack and FIFO non-empty: pop next entry into output registers, stay REQ, request held high (back-to-back, no gap).
REQ-027 REQ with ack and FIFO empty: o_sdramWrReq=0 next cycle, go IDLE.
REQ-028 i_sdramWrAck in IDLE SHALL be ignored.
REQ-029 Latency: word sampled at edge N appears with o_sdramWrReq=1 after edge N+2 when the buffer was idle and empty.
REQ-030 Order SHALL be strictly FIFO; no word duplicated or lost except per REQ-019.
REQ-031 Sustained throughput: one word per cycle when ack is asserted every cycle.

Reset
REQ-032 i_rst_n=0 at an edge SHALL clear pointers and occupancy and force FSM to IDLE.
REQ-033 Reset values: o_empty=1, o_full=0, o_busy=0, o_sdramWrReq=0, o_sdramAddr=0, o_sdramData=0, o_overflow=0.
REQ-034 Reset mid-request SHALL drop the in-flight request and all buffered words; an ack during reset is ignored.

Configuration
REQ-035 Macro SDRAM_WRBUF_OVERFLOW_EN defined: o_overflow sets on any REQ-019 drop, clears on i_clrOverflow=1; set wins if both occur in the same cycle.
REQ-036 Macro SDRAM_WRBUF_OVERFLOW_EN undefined: o_overflow tied 0, i_clrOverflow unused; all other behaviour identical.

Verification
REQ-037 Single write addr=0x00010, data=0xBEEF, ack 3 cycles after req -> req high after edge N+2, outputs stable until ack, req low next cycle, o_busy=0.
REQ-038 Four writes (0x1..0x4, data 0xA001..0xA004), ack held high -> four consecutive req cycles, in order, no gap.
REQ-039 DEPTH=16, ack held low, 18 writes -> o_full=1 once buffer full, last excess words dropped, o_overflow=1 (macro defined) / 0 (undefined).
REQ-040 Full FIFO with push and ack in the same cycle -> push refused, occupancy decrements by 1, o_full=0 next cycle.
REQ-041 Reset asserted while req high with 5 words queued -> all outputs at reset values next cycle, later ack pulse produces no activity.
REQ-042 Pointer wrap: 40 writes with random ack gaps -> all 40 words emitted in order with correct addr/data.
